// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants: opcodes, forwarding selects,
// hazard FSM states and the canonical NOP used by IF/ID and ID/EX.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    // EX-stage match wins because it holds the younger producer.
    function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the EX and MEM destination-register info, shifted in step
// with the pipeline; a bubble entering EX carries no write or load.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_advance,
    input  logic                  i_bubble,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_we,
    input  logic                  i_id_load,
    output logic [REG_ADDR_W-1:0] o_ex_rd,
    output logic                  o_ex_we,
    output logic                  o_ex_load,
    output logic [REG_ADDR_W-1:0] o_mem_rd,
    output logic                  o_mem_we,
    output logic                  o_mem_load
);

    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_we;
    logic                  r_ex_load;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_we;
    logic                  r_mem_load;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ex_rd    <= '0;
            r_ex_we    <= 1'b0;
            r_ex_load  <= 1'b0;
            r_mem_rd   <= '0;
            r_mem_we   <= 1'b0;
            r_mem_load <= 1'b0;
        end else if (i_advance) begin
            r_mem_rd   <= r_ex_rd;
            r_mem_we   <= r_ex_we;
            r_mem_load <= r_ex_load;
            r_ex_rd    <= i_id_rd;
            r_ex_we    <= i_id_we && !i_bubble;
            r_ex_load  <= i_id_load && !i_bubble;
        end
    end

    assign o_ex_rd    = r_ex_rd;
    assign o_ex_we    = r_ex_we;
    assign o_ex_load  = r_ex_load;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_we   = r_mem_we;
    assign o_mem_load = r_mem_load;

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard detection and forwarding-select generation for ID/EX.
// Optional stall/flush event counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_forward_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            busywait,
    input  logic [XLEN-1:0] id_instruction,
    input  logic            id_reg_write_en,
    input  logic            id_is_load,
    input  logic            branch_taken,
    output logic            NOP_sel,
    output logic            stall_IF_ID,
    output logic            flush_IF_ID,
    output logic [1:0]      fwd1_sel,
    output logic [1:0]      fwd2_sel,
    output logic            mem_data_fwd
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    logic [6:0]            w_opcode;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic [REG_ADDR_W-1:0] w_ex_rd;
    logic                  w_ex_we;
    logic                  w_ex_load;
    logic [REG_ADDR_W-1:0] w_mem_rd;
    logic                  w_mem_we;
    logic                  w_mem_load;
    logic                  w_rs1_ex;
    logic                  w_rs2_ex;
    logic                  w_rs1_mem;
    logic                  w_rs2_mem;
    logic                  w_load_hit;
    logic                  w_store_bypass;
    logic                  w_load_use;
    logic                  w_branch;
    logic                  w_unused_bits;
    hz_state_t             r_state;
    hz_state_t             w_state_next;

    assign w_opcode = id_instruction[6:0];
    assign w_rd     = id_instruction[7 +: REG_ADDR_W];
    assign w_rs1    = id_instruction[15 +: REG_ADDR_W];
    assign w_rs2    = id_instruction[20 +: REG_ADDR_W];

    assign w_unused_bits = ^{id_instruction[XLEN-1:25], id_instruction[14:12], w_mem_load};

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_OP, OP_STORE, OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: w_use_rs1 = 1'b1;
            OP_LUI, OP_AUIPC, OP_JAL: ;
            default: ;
        endcase
    end

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_advance  (!busywait),
        .i_bubble   (NOP_sel),
        .i_id_rd    (w_rd),
        .i_id_we    (id_reg_write_en),
        .i_id_load  (id_is_load),
        .o_ex_rd    (w_ex_rd),
        .o_ex_we    (w_ex_we),
        .o_ex_load  (w_ex_load),
        .o_mem_rd   (w_mem_rd),
        .o_mem_we   (w_mem_we),
        .o_mem_load (w_mem_load)
    );

    // Register-index matches; x0 and unused source fields never match.
    assign w_rs1_ex  = w_use_rs1 && (w_rs1 != '0) && (w_rs1 == w_ex_rd);
    assign w_rs2_ex  = w_use_rs2 && (w_rs2 != '0) && (w_rs2 == w_ex_rd);
    assign w_rs1_mem = w_use_rs1 && (w_rs1 != '0) && (w_rs1 == w_mem_rd) && w_mem_we;
    assign w_rs2_mem = w_use_rs2 && (w_rs2 != '0) && (w_rs2 == w_mem_rd) && w_mem_we;

    assign w_load_hit     = w_ex_load && (w_ex_rd != '0) && (w_rs1_ex || w_rs2_ex);
    // Store data can wait for the load value at MEM; only the address cannot.
    assign w_store_bypass = w_load_hit && (w_opcode == OP_STORE) && w_rs2_ex && !w_rs1_ex;
    assign w_load_use     = w_load_hit && !w_store_bypass;
    assign w_branch       = branch_taken && (r_state != FLUSH);

    always_comb begin
        NOP_sel      = w_branch || w_load_use;
        stall_IF_ID  = w_load_use && !w_branch;
        flush_IF_ID  = w_branch;
        fwd1_sel     = fwd_pick(w_rs1_ex && w_ex_we, w_rs1_mem);
        fwd2_sel     = w_store_bypass ? FWD_RF : fwd_pick(w_rs2_ex && w_ex_we, w_rs2_mem);
        mem_data_fwd = w_store_bypass;
    end

    always_comb begin
        w_state_next = RUN;
        if (w_branch) begin
            w_state_next = FLUSH;
        end else if (w_load_use) begin
            w_state_next = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else if (!busywait) begin
            r_state <= w_state_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!busywait) begin
            if (stall_IF_ID) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_IF_ID) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit; each row is one cycle
// of inputs with the outputs expected before the next clock edge.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busywait;
    logic [31:0] id_instruction;
    logic        id_reg_write_en;
    logic        id_is_load;
    logic        branch_taken;
    logic        NOP_sel;
    logic        stall_IF_ID;
    logic        flush_IF_ID;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic        mem_data_fwd;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .busywait        (busywait),
        .id_instruction  (id_instruction),
        .id_reg_write_en (id_reg_write_en),
        .id_is_load      (id_is_load),
        .branch_taken    (branch_taken),
        .NOP_sel         (NOP_sel),
        .stall_IF_ID     (stall_IF_ID),
        .flush_IF_ID     (flush_IF_ID),
        .fwd1_sel        (fwd1_sel),
        .fwd2_sel        (fwd2_sel),
        .mem_data_fwd    (mem_data_fwd)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        chk;
        logic        bw;
        logic [31:0] instr;
        logic        we;
        logic        ld;
        logic        br;
        logic        nop;
        logic        stall;
        logic        flush;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        mdf;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall_cnt = 0;
    int   exp_flush_cnt = 0;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [31:0] NOPI = 32'h00000013;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                        input int rs2);
        logic [31:0] w;
        w        = '0;
        w[6:0]   = op;
        w[11:7]  = rd[4:0];
        w[19:15] = rs1[4:0];
        w[24:20] = rs2[4:0];
        return w;
    endfunction

    function automatic vec_t mk(input logic rst_n, input logic chk, input logic bw,
                                input logic [31:0] ins, input logic we, input logic ld,
                                input logic br, input logic nop, input logic st, input logic fl,
                                input logic [1:0] f1, input logic [1:0] f2, input logic mdf);
        vec_t v;
        v.rst_n = rst_n; v.chk = chk; v.bw = bw; v.instr = ins; v.we = we; v.ld = ld;
        v.br = br; v.nop = nop; v.stall = st; v.flush = fl; v.f1 = f1; v.f2 = f2; v.mdf = mdf;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at posedge+1, check at negedge, then let the edge advance state.
    task automatic run_vec(input vec_t v, input int idx);
        reset_n         = v.rst_n;
        busywait        = v.bw;
        id_instruction  = v.instr;
        id_reg_write_en = v.we;
        id_is_load      = v.ld;
        branch_taken    = v.br;
        @(negedge clk);
        if (v.chk) begin
            cmp($sformatf("v%0d.NOP_sel", idx), {31'd0, NOP_sel}, {31'd0, v.nop});
            cmp($sformatf("v%0d.stall_IF_ID", idx), {31'd0, stall_IF_ID}, {31'd0, v.stall});
            cmp($sformatf("v%0d.flush_IF_ID", idx), {31'd0, flush_IF_ID}, {31'd0, v.flush});
            cmp($sformatf("v%0d.fwd1_sel", idx), {30'd0, fwd1_sel}, {30'd0, v.f1});
            cmp($sformatf("v%0d.fwd2_sel", idx), {30'd0, fwd2_sel}, {30'd0, v.f2});
            cmp($sformatf("v%0d.mem_data_fwd", idx), {31'd0, mem_data_fwd}, {31'd0, v.mdf});
`ifdef HAZARD_PERF_CNT_EN
            cmp($sformatf("v%0d.stall_cnt", idx), stall_cnt, exp_stall_cnt);
            cmp($sformatf("v%0d.flush_cnt", idx), flush_cnt, exp_flush_cnt);
`endif
        end
        @(posedge clk);
        if (!v.rst_n) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else if (!v.bw) begin
            exp_stall_cnt += int'(v.stall);
            exp_flush_cnt += int'(v.flush);
        end
        #1;
    endtask

    logic [31:0] add5, sub6, add8, add9_88, add9_11, add10, lw5, add6_55, sw_5_2, sw_7_5;
    logic [31:0] sw_5_5, addi_x0, add1_00, lw0, add2_00, lui3, addi4, lw5_0, add6_50;

    initial begin
        add5    = enc(R_OP, 5, 1, 2);
        sub6    = enc(R_OP, 6, 5, 3);
        add8    = enc(R_OP, 8, 5, 6);
        add9_88 = enc(R_OP, 9, 8, 8);
        add9_11 = enc(R_OP, 9, 1, 1);
        add10   = enc(R_OP, 10, 9, 0);
        lw5     = enc(LD_OP, 5, 1, 0);
        add6_55 = enc(R_OP, 6, 5, 5);
        sw_5_2  = enc(ST_OP, 4, 2, 5);
        sw_7_5  = enc(ST_OP, 0, 5, 7);
        sw_5_5  = enc(ST_OP, 0, 5, 5);
        addi_x0 = enc(I_OP, 0, 0, 1);
        add1_00 = enc(R_OP, 1, 0, 0);
        lw0     = enc(LD_OP, 0, 2, 0);
        add2_00 = enc(R_OP, 2, 0, 0);
        lui3    = enc(LUI_OP, 3, 2, 2);
        addi4   = enc(I_OP, 4, 3, 3);
        lw5_0   = enc(LD_OP, 5, 0, 0);
        add6_50 = enc(R_OP, 6, 5, 0);

        //              rst chk bw instr    we ld br  nop st fl f1     f2     mdf
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0)); // reset state
        tbl.push_back(mk(1, 1, 0, add5,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, sub6,    1, 0, 0,  0, 0, 0, 2'b01, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add8,    1, 0, 0,  0, 0, 0, 2'b10, 2'b01, 0));
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add9_88, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10, 0)); // gap -> MEM
        tbl.push_back(mk(1, 1, 0, add9_11, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add10,   1, 0, 0,  0, 0, 0, 2'b01, 2'b00, 0)); // EX over MEM
        tbl.push_back(mk(1, 1, 0, lw5,     1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add6_55, 1, 0, 0,  1, 1, 0, 2'b01, 2'b01, 0)); // load-use
        tbl.push_back(mk(1, 1, 0, add6_55, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10, 0));
        tbl.push_back(mk(1, 1, 0, lw5,     1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, sw_5_2,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1)); // store data
        tbl.push_back(mk(1, 1, 0, lw5,     1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, sw_7_5,  0, 0, 0,  1, 1, 0, 2'b01, 2'b00, 0)); // store addr
        tbl.push_back(mk(1, 1, 0, sw_7_5,  0, 0, 0,  0, 0, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, lw5,     1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, sw_5_5,  0, 0, 0,  1, 1, 0, 2'b01, 2'b01, 0)); // both match
        tbl.push_back(mk(1, 1, 0, sw_5_5,  0, 0, 0,  0, 0, 0, 2'b10, 2'b10, 0));
        tbl.push_back(mk(1, 1, 0, addi_x0, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0)); // x0 dest
        tbl.push_back(mk(1, 1, 0, add1_00, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, lw0,     1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add2_00, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0)); // load x0
        tbl.push_back(mk(1, 1, 0, lui3,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0)); // no rs used
        tbl.push_back(mk(1, 1, 0, addi4,   1, 0, 0,  0, 0, 0, 2'b01, 2'b00, 0)); // rs2 unused
        tbl.push_back(mk(1, 1, 0, lw5_0,   1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, add6_50, 1, 0, 1,  1, 0, 1, 2'b01, 2'b00, 0)); // br > load
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 1,  0, 0, 0, 2'b00, 2'b00, 0)); // FLUSH ign.
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 1,  1, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, NOPI,    1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk(1, 1, 0, lw5_0,   1, 1, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1, 1, 1, add6_55, 1, 0, 0, 1, 1, 0, 2'b01, 2'b01, 0)); // busywait
        end
        tbl.push_back(mk(1, 1, 0, add6_55, 1, 0, 0,  1, 1, 0, 2'b01, 2'b01, 0));
        tbl.push_back(mk(1, 1, 0, add6_55, 1, 0, 0,  0, 0, 0, 2'b10, 2'b10, 0));

        reset_n         = 1'b0;
        busywait        = 1'b0;
        id_instruction  = NOPI;
        id_reg_write_en = 1'b1;
        id_is_load      = 1'b0;
        branch_taken    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
        end

        // Reset while in FLUSH with a load still in the shadow MEM slot.
        run_vec(mk(1, 1, 0, lw5_0,   1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0), 100);
        run_vec(mk(1, 1, 0, add6_55, 1, 0, 1, 1, 0, 1, 2'b01, 2'b01, 0), 101);
        run_vec(mk(0, 0, 0, add6_55, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 102);
        run_vec(mk(1, 1, 0, add6_55, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 103);

        // Reset at the edge that would enter FLUSH: the next branch must act.
        run_vec(mk(0, 0, 0, NOPI,    1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0), 110);
        run_vec(mk(1, 1, 0, NOPI,    1, 0, 1, 1, 0, 1, 2'b00, 2'b00, 0), 111);
        run_vec(mk(1, 1, 0, NOPI,    1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0), 112);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
